// File: rtl/spec_free_list.sv
// Speculative free list of physical register tags for rename.
// Define FREE_LIST_CHECK_EN to enable the sticky overflow/underflow error flag.
module spec_free_list #(
    parameter int PHYS_REGS = 96,
    parameter int LOG_REGS  = 32,
    parameter int PHYS_LOG  = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                allocReq_i,
    input  logic [2:0]          allocCount_i,
    output logic [PHYS_LOG-1:0] freeReg0_o,
    output logic [PHYS_LOG-1:0] freeReg1_o,
    output logic [PHYS_LOG-1:0] freeReg2_o,
    output logic [PHYS_LOG-1:0] freeReg3_o,
    output logic                stall_o,
    input  logic                releasedValid0_i,
    input  logic                releasedValid1_i,
    input  logic                releasedValid2_i,
    input  logic                releasedValid3_i,
    input  logic [PHYS_LOG-1:0] releasedPhyMap0_i,
    input  logic [PHYS_LOG-1:0] releasedPhyMap1_i,
    input  logic [PHYS_LOG-1:0] releasedPhyMap2_i,
    input  logic [PHYS_LOG-1:0] releasedPhyMap3_i,
    input  logic                recoverFlag_i,
    output logic [PHYS_LOG-1:0] freeCount_o,
    output logic                errFlag_o
);

    localparam int DEPTH = PHYS_REGS - LOG_REGS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PHYS_LOG + 2;

    typedef logic [PTR_W-1:0] ptr_t;

    // Modulo add without a power-of-two depth: compare and subtract once.
    function automatic ptr_t wrapAdd(input ptr_t p, input logic [2:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH))
            s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    logic [PHYS_LOG-1:0] entries [DEPTH];
    ptr_t                head;
    ptr_t                tail;
    logic [PHYS_LOG-1:0] count;

    logic [3:0]          relV;
    logic [PHYS_LOG-1:0] relTag [4];
    logic [2:0]          relOff [4];
    ptr_t                relIdx [4];
    logic [2:0]          relN;
    logic                grant;
    logic [2:0]          grantAmt;
    logic [CW-1:0]       cntWide;

    assign relV      = {releasedValid3_i, releasedValid2_i,
                        releasedValid1_i, releasedValid0_i};
    assign relTag[0] = releasedPhyMap0_i;
    assign relTag[1] = releasedPhyMap1_i;
    assign relTag[2] = releasedPhyMap2_i;
    assign relTag[3] = releasedPhyMap3_i;

    assign stall_o  = count < PHYS_LOG'(4);
    assign grant    = allocReq_i && !stall_o;
    assign grantAmt = grant ? allocCount_i : 3'd0;

    // Valid release slots are packed in slot order behind tail.
    always_comb begin
        relOff[0] = 3'd0;
        relOff[1] = relOff[0] + {2'b0, relV[0]};
        relOff[2] = relOff[1] + {2'b0, relV[1]};
        relOff[3] = relOff[2] + {2'b0, relV[2]};
        relN      = relOff[3] + {2'b0, relV[3]};
        for (int k = 0; k < 4; k++)
            relIdx[k] = wrapAdd(tail, relOff[k]);
    end

    assign cntWide = CW'(count) + CW'(relN) - CW'(grantAmt);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= PHYS_LOG'(LOG_REGS + i);
            head  <= '0;
            tail  <= '0;
            count <= PHYS_LOG'(DEPTH);
        end else if (recoverFlag_i) begin
            head  <= tail;
            count <= PHYS_LOG'(DEPTH);
        end else begin
            for (int k = 0; k < 4; k++)
                if (relV[k])
                    entries[relIdx[k]] <= relTag[k];
            head  <= wrapAdd(head, grantAmt);
            tail  <= wrapAdd(tail, relN);
            count <= cntWide[PHYS_LOG-1:0];
        end
    end

    assign freeReg0_o  = entries[head];
    assign freeReg1_o  = entries[wrapAdd(head, 3'd1)];
    assign freeReg2_o  = entries[wrapAdd(head, 3'd2)];
    assign freeReg3_o  = entries[wrapAdd(head, 3'd3)];
    assign freeCount_o = count;

`ifdef FREE_LIST_CHECK_EN
    logic errQ;
    logic overflow;
    logic underflow;
    logic recRelease;

    assign overflow   = !recoverFlag_i && (cntWide > CW'(DEPTH));
    assign underflow  = !recoverFlag_i && grant &&
                        (PHYS_LOG'(allocCount_i) > count);
    assign recRelease = recoverFlag_i && (relV != 4'b0);

    always_ff @(posedge clk) begin
        if (reset)
            errQ <= 1'b0;
        else if (overflow || underflow || recRelease)
            errQ <= 1'b1;
    end

    assign errFlag_o = errQ;
`else
    assign errFlag_o = 1'b0;
`endif

endmodule

// File: tb/tb_spec_free_list.sv
// Directed-vector bench for spec_free_list.
module tb_spec_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       allocReq;
    logic [2:0] allocCount;
    logic [6:0] fr0, fr1, fr2, fr3;
    logic       stall;
    logic [3:0] rv;
    logic [6:0] rt0, rt1, rt2, rt3;
    logic       recover;
    logic [6:0] freeCount;
    logic       errFlag;

    int nVec = 0;
    int nMis = 0;
    int expErr;

    always #5 clk = ~clk;

    spec_free_list dut (
        .clk               (clk),
        .reset             (reset),
        .allocReq_i        (allocReq),
        .allocCount_i      (allocCount),
        .freeReg0_o        (fr0),
        .freeReg1_o        (fr1),
        .freeReg2_o        (fr2),
        .freeReg3_o        (fr3),
        .stall_o           (stall),
        .releasedValid0_i  (rv[0]),
        .releasedValid1_i  (rv[1]),
        .releasedValid2_i  (rv[2]),
        .releasedValid3_i  (rv[3]),
        .releasedPhyMap0_i (rt0),
        .releasedPhyMap1_i (rt1),
        .releasedPhyMap2_i (rt2),
        .releasedPhyMap3_i (rt3),
        .recoverFlag_i     (recover),
        .freeCount_o       (freeCount),
        .errFlag_o         (errFlag)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nVec++;
        if (got != exp) begin
            nMis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic req, input int n,
                       input logic [3:0] v, input int t0, input int t1,
                       input int t2, input int t3, input logic rec);
        reset      = rst;
        allocReq   = req;
        allocCount = 3'(n);
        rv         = v;
        rt0        = 7'(t0);
        rt1        = 7'(t1);
        rt2        = 7'(t2);
        rt3        = 7'(t3);
        recover    = rec;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        allocReq = 1'b0;
        rv       = 4'b0;
        recover  = 1'b0;
    endtask

    task automatic doReset();
        cyc(1'b1, 1'b0, 0, 4'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic alloc(input int n);
        cyc(1'b0, 1'b1, n, 4'b0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
`ifdef FREE_LIST_CHECK_EN
        expErr = 1;
`else
        expErr = 0;
`endif
        reset = 1'b0; allocReq = 1'b0; allocCount = '0;
        rv = '0; rt0 = '0; rt1 = '0; rt2 = '0; rt3 = '0; recover = 1'b0;
        @(negedge clk);

        doReset();
        chk("rst_count", freeCount, 64);
        chk("rst_fr0", fr0, 32);
        chk("rst_fr1", fr1, 33);
        chk("rst_fr2", fr2, 34);
        chk("rst_fr3", fr3, 35);
        chk("rst_stall", stall, 0);
        chk("rst_err", errFlag, 0);

        for (int i = 0; i < 15; i++) alloc(4);
        chk("a15_count", freeCount, 4);
        chk("a15_fr0", fr0, 92);
        chk("a15_fr3", fr3, 95);
        chk("a15_stall", stall, 0);
        alloc(4);
        chk("a16_count", freeCount, 0);
        chk("a16_stall", stall, 1);
        alloc(4);
        chk("stalled_count", freeCount, 0);

        cyc(1'b0, 1'b0, 0, 4'b0101, 40, 99, 41, 98, 1'b0);
        chk("r1010_count", freeCount, 2);
        chk("r1010_fr0", fr0, 40);
        chk("r1010_fr1", fr1, 41);
        chk("r1010_stall", stall, 1);

        doReset();
        for (int i = 0; i < 16; i++) alloc(4);
        cyc(1'b0, 1'b0, 0, 4'b1111, 80, 81, 82, 83, 1'b0);
        chk("w_rel4_count", freeCount, 4);
        chk("w_rel4_fr0", fr0, 80);
        for (int i = 0; i < 14; i++)
            cyc(1'b0, 1'b1, 4, 4'b1111, 50, 51, 52, 53, 1'b0);
        chk("w_ar4_count", freeCount, 4);
        cyc(1'b0, 1'b1, 2, 4'b0011, 54, 55, 0, 0, 1'b0);
        alloc(4);
        chk("w_drain_count", freeCount, 0);
        cyc(1'b0, 1'b0, 0, 4'b1111, 70, 71, 72, 73, 1'b0);
        chk("w_count", freeCount, 4);
        chk("w_fr0", fr0, 70);
        chk("w_fr1", fr1, 71);
        chk("w_fr2", fr2, 72);
        chk("w_fr3", fr3, 73);
        alloc(2);
        chk("w_a2_fr0", fr0, 72);
        chk("w_a2_fr1", fr1, 73);
        chk("w_a2_count", freeCount, 2);

        doReset();
        for (int i = 0; i < 3; i++) alloc(4);
        chk("rec_pre_count", freeCount, 52);
        chk("rec_pre_fr0", fr0, 44);
        cyc(1'b0, 1'b1, 4, 4'b0, 0, 0, 0, 0, 1'b1);
        chk("rec_count", freeCount, 64);
        chk("rec_fr0", fr0, 32);
        chk("rec_stall", stall, 0);
        chk("rec_err", errFlag, 0);

        alloc(4);
        chk("mid_fr0", fr0, 36);
        cyc(1'b1, 1'b1, 4, 4'b0, 0, 0, 0, 0, 1'b0);
        chk("rstmid_count", freeCount, 64);
        chk("rstmid_fr0", fr0, 32);

        cyc(1'b0, 1'b0, 0, 4'b1111, 60, 61, 62, 63, 1'b0);
        chk("ovf_err", errFlag, expErr);
        cyc(1'b0, 1'b0, 0, 4'b0, 0, 0, 0, 0, 1'b0);
        chk("ovf_err_held", errFlag, expErr);
        doReset();
        chk("ovf_err_cleared", errFlag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
